free_list_mw: RTL
=================

FREE_LIST_MW -- requirements
Module: free_list_mw

Interface
REQ-001 Parameter NUM_PREG, default 64: number of physical registers.
REQ-002 Parameter NUM_AREG, default 32: number of architectural registers; list depth DEPTH = NUM_PREG-NUM_AREG.
REQ-003 Parameter WAYS, default 2: number of dispatch lanes and retire lanes.
REQ-004 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 dispatch_req_i  in  WAYS  per-lane request for a free preg; lane 0 is the oldest.
REQ-007 retire_en_i  in  WAYS  per-lane release of a preg.
REQ-008 retire_preg_i  in  WAYS x PREG_W  released preg per lane.
REQ-009 recover_en_i  in  1  branch recovery strobe.
REQ-010 recover_head_i  in  PTR_W  checkpointed head pointer to restore.
REQ-011 free_preg_vld_o  out  WAYS  lane grant.
REQ-012 free_preg_o  out  WAYS x PREG_W  allocated preg per lane; 0 when not granted.
REQ-013 head_o  out  PTR_W  current head pointer, before this cycle's advance, for ROB checkpointing.
REQ-014 free_cnt_o  out  CNT_W  current occupancy.
REQ-015 overflow_o  out  1  one-cycle pulse on an illegal retire beyond capacity.

Function
REQ-016 Widths: PREG_W=clog2(NUM_PREG); PTR_W=clog2(DEPTH)+1 (MSB is the wrap bit); CNT_W=clog2(DEPTH)+1.
REQ-017 Occupancy: count = tail-head, computed modulo 2^PTR_W; empty when count=0; full when count=DEPTH.
REQ-018 Allocation is all-or-nothing: alloc_ok = (popcount(dispatch_req_i) <= avail) and not recover_en_i.
REQ-019 Grant: free_preg_vld_o[k] = dispatch_req_i[k] and alloc_ok; the output is combinational, with zero-cycle latency.
REQ-020 Lane index: granted lane k reads FL[head + prefix(k)], where prefix(k) counts the requesting lanes below k; indices wrap modulo DEPTH.
REQ-021 Head update: on alloc_ok, head advances by popcount(dispatch_req_i) at the next edge.
REQ-022 Retire write: active retire lane k writes FL[tail + rprefix(k)], where rprefix(k) counts the active retire lanes below k; tail advances by popcount(retire_en_i).
REQ-023 Overflow: if count - allocated + popcount(retire_en_i) > DEPTH, all retire writes that cycle are dropped, tail holds, and overflow_o pulses.
REQ-024 Recovery: recover_en_i loads head <= recover_head_i and suppresses every grant in the same cycle.
REQ-025 Recovery with retire: retires in a recovery cycle still write and advance tail.
REQ-026 Simultaneous dispatch and retire: both pointers update independently; count follows from the pointers.

Reset
REQ-027 rst fills FL[i] = NUM_AREG+i for i in 0..DEPTH-1, sets head=0, and sets tail=DEPTH (wrap bit 1, index 0), i.e. the list starts full.
REQ-028 Outputs after reset: free_preg_vld_o=0 and overflow_o=0; free_cnt_o=DEPTH at the first cycle.
REQ-029 rst asserted mid-operation overrides dispatch, retire and recovery in that cycle.

Configuration
REQ-030 Macro FREE_LIST_BYPASS_EN.
REQ-031 With FREE_LIST_BYPASS_EN defined: avail = count + popcount(retire_en_i); a lane whose index j >= count receives retire_preg_i of the (j-count)-th active retire lane.
REQ-032 With bypass, those bypassed retires are consumed and not written to FL; tail advances only by the unbypassed retires.
REQ-033 Without FREE_LIST_BYPASS_EN: avail = count; no same-cycle forwarding.

Structure
REQ-034 Package fl_pkg holds NUM_PREG, NUM_AREG, WAYS, derived widths, and typedefs preg_t and fl_ptr_t.
REQ-035 Sub-module fl_prefix_cnt (WAYS-bit prefix popcount) is instantiated for dispatch and for retire; there is no other hierarchy.

Verification
REQ-036 Reset, then dispatch_req_i=2'b11 -> vld=2'b11, pregs 32 and 33; next cycle free_cnt_o=30 and head_o=2.
REQ-037 dispatch_req_i=2'b10 alone -> lane 1 gets FL[head] (lane 0 not granted), head+1.
REQ-038 Drain to count=1, then request 2'b11 with no retire -> vld=2'b00, head unchanged (bypass off). With FREE_LIST_BYPASS_EN and retire lane 0 = preg 7 -> lane 1 receives 7.
REQ-039 Checkpoint head_o=5, dispatch 4, recover_en_i with recover_head_i=5 plus requests -> no grants; next cycle head_o=5.
REQ-040 Full list (reset), retire preg 40 -> overflow_o pulse, free_cnt_o stays 32; wrap test: 40 alloc/retire cycles -> pointers wrap and pregs return in FIFO order.

Source files
------------

// File: rtl/fl_pkg.sv
// Shared sizing and types for the multi-way physical-register free list.
// Defaults: 64 pregs, 32 aregs, 2 dispatch/retire lanes.
package fl_pkg;
    localparam int NUM_PREG = 64;
    localparam int NUM_AREG = 32;
    localparam int WAYS     = 2;
    localparam int DEPTH    = NUM_PREG - NUM_AREG;
    localparam int PREG_W   = $clog2(NUM_PREG);
    localparam int PTR_W    = $clog2(DEPTH) + 1;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;
endpackage

// File: rtl/fl_prefix_cnt.sv
// Exclusive prefix popcount of a lane mask, plus total popcount.
// Purely combinational, no flow control.
module fl_prefix_cnt #(
    parameter int WAYS = 2,
    parameter int CW   = $clog2(WAYS + 1)
) (
    input  logic [WAYS-1:0]         bits,
    output logic [WAYS-1:0][CW-1:0] prefix,
    output logic [CW-1:0]           total
);
    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        for (int k = 0; k < WAYS; k++) begin
            prefix[k] = acc;
            acc       = acc + CW'(bits[k]);
        end
        total = acc;
    end
endmodule

// File: rtl/free_list_mw.sv
// Multi-way circular free list of physical registers; grants are combinational, pointers update next edge.
// Optional FREE_LIST_BYPASS_EN forwards same-cycle retired pregs to lanes beyond current occupancy.
module free_list_mw import fl_pkg::*; #(
    parameter int NUM_PREG = fl_pkg::NUM_PREG,
    parameter int NUM_AREG = fl_pkg::NUM_AREG,
    parameter int WAYS     = fl_pkg::WAYS
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [WAYS-1:0]                            dispatch_req_i,
    input  logic [WAYS-1:0]                            retire_en_i,
    input  logic [WAYS-1:0][$clog2(NUM_PREG)-1:0]      retire_preg_i,
    input  logic                                       recover_en_i,
    input  logic [$clog2(NUM_PREG-NUM_AREG):0]         recover_head_i,
    output logic [WAYS-1:0]                            free_preg_vld_o,
    output logic [WAYS-1:0][$clog2(NUM_PREG)-1:0]      free_preg_o,
    output logic [$clog2(NUM_PREG-NUM_AREG):0]         head_o,
    output logic [$clog2(NUM_PREG-NUM_AREG):0]         free_cnt_o,
    output logic                                       overflow_o
);
    localparam int DEPTH  = NUM_PREG - NUM_AREG;
    localparam int PREG_W = $clog2(NUM_PREG);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int CNT_W  = IDX_W + 1;
    localparam int CW     = $clog2(WAYS + 1);
    localparam int EW     = CNT_W + 1;

    logic [PREG_W-1:0]        fl [DEPTH];
    logic [PTR_W-1:0]         head, tail;
    logic [CNT_W-1:0]         count;
    logic [WAYS-1:0][CW-1:0]  d_pre, r_pre;
    logic [CW-1:0]            d_tot, r_tot;
    logic [EW-1:0]            avail, n_alloc, n_byp;
    logic                     alloc_ok, overflow;

    fl_prefix_cnt #(.WAYS(WAYS), .CW(CW)) u_disp_cnt (
        .bits   (dispatch_req_i),
        .prefix (d_pre),
        .total  (d_tot)
    );

    fl_prefix_cnt #(.WAYS(WAYS), .CW(CW)) u_ret_cnt (
        .bits   (retire_en_i),
        .prefix (r_pre),
        .total  (r_tot)
    );

    assign count       = CNT_W'(tail - head);
    assign head_o      = head;
    assign free_cnt_o  = count;
    assign overflow_o  = overflow;

    always_comb begin
        logic [IDX_W-1:0] rd_idx;
        rd_idx = '0;
`ifdef FREE_LIST_BYPASS_EN
        avail = EW'(count) + EW'(r_tot);
`else
        avail = EW'(count);
`endif
        alloc_ok = !rst && !recover_en_i && (EW'(d_tot) <= avail);
        n_alloc  = alloc_ok ? EW'(d_tot) : '0;
        n_byp    = '0;
`ifdef FREE_LIST_BYPASS_EN
        if (n_alloc > EW'(count))
            n_byp = n_alloc - EW'(count);
`endif
        // Occupancy after this cycle; bypassed retires cancel bypassed grants.
        overflow = !rst && ((EW'(count) + EW'(r_tot) - n_alloc) > EW'(DEPTH));

        for (int k = 0; k < WAYS; k++) begin
            free_preg_vld_o[k] = dispatch_req_i[k] & alloc_ok;
            free_preg_o[k]     = '0;
            if (free_preg_vld_o[k]) begin
                rd_idx         = head[IDX_W-1:0] + IDX_W'(d_pre[k]);
                free_preg_o[k] = fl[rd_idx];
`ifdef FREE_LIST_BYPASS_EN
                if (EW'(d_pre[k]) >= EW'(count)) begin
                    for (int l = 0; l < WAYS; l++) begin
                        if (retire_en_i[l] && (EW'(r_pre[l]) == EW'(d_pre[k]) - EW'(count)))
                            free_preg_o[k] = retire_preg_i[l];
                    end
                end
`endif
            end
        end
    end

    // Head only consumes entries actually read from the array, so count stays tail-head.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= PTR_W'(DEPTH);
            for (int i = 0; i < DEPTH; i++)
                fl[i] <= PREG_W'(NUM_AREG + i);
        end else begin
            if (recover_en_i)
                head <= recover_head_i;
            else if (alloc_ok)
                head <= head + PTR_W'(n_alloc - n_byp);
            if (!overflow) begin
                for (int l = 0; l < WAYS; l++) begin
                    if (retire_en_i[l] && (EW'(r_pre[l]) >= n_byp))
                        fl[tail[IDX_W-1:0] + IDX_W'(EW'(r_pre[l]) - n_byp)] <= retire_preg_i[l];
                end
                tail <= tail + PTR_W'(EW'(r_tot) - n_byp);
            end
        end
    end
endmodule
